// File: rtl/tmr_fault_monitor.sv
// Fault monitor downstream of a TMR voter. It flags lanes that disagree with the
// vote, counts mismatching cycles, latches persistent lane faults and reports health.
module tmr_fault_monitor #(
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             y,
  output logic [2:0]       mis,
  output logic [2:0]       lane_fault,
  output logic             voter_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       status
);

  localparam int RUN_W = $clog2(FAULT_THRESH + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FAULT_THRESH);

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_DEGRADED = 2'b01,
    ST_FAILED   = 2'b10
  } status_e;

  logic [2:0]       lane_d;
  logic             valid_d;
  logic [RUN_W-1:0] run     [3];
  logic [RUN_W-1:0] run_nxt [3];
  status_e          state;
  status_e          state_nxt;

  logic [2:0]       m;
  logic             maj_d;
  logic             verr;
  logic [2:0]       lf_nxt;
  logic             ve_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             multi_fault;

  // y is registered by the voter on the same edge that captures lane_d,
  // so after that edge both refer to the same lane samples.
  assign maj_d = (lane_d[0] & lane_d[1]) | (lane_d[0] & lane_d[2]) | (lane_d[1] & lane_d[2]);
  assign m     = {3{valid_d}} & (lane_d ^ {3{y}});
  assign verr  = valid_d & (y ^ maj_d);

  assign multi_fault = (lf_nxt[0] & lf_nxt[1]) | (lf_nxt[0] & lf_nxt[2]) | (lf_nxt[1] & lf_nxt[2]);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    lf_nxt    = lane_fault;
    ve_nxt    = voter_err | verr;
    cnt_nxt   = err_cnt;
    state_nxt = state;

    for (int i = 0; i < 3; i++) begin
      run_nxt[i] = run[i];
      if (m[i]) begin
        if (run[i] != RUN_MAX) run_nxt[i] = run[i] + 1'b1;
      end else if (valid_d) begin
        run_nxt[i] = '0;
      end
      if (run_nxt[i] == RUN_MAX) lf_nxt[i] = 1'b1;
    end

    if ((|m) && (err_cnt != {CNT_W{1'b1}})) cnt_nxt = err_cnt + 1'b1;

    // Status looks at next-state flags so FAILED lands on the same edge as the fault.
    if (state != ST_FAILED) begin
      if (multi_fault || ve_nxt) state_nxt = ST_FAILED;
      else if (lf_nxt != 3'b000) state_nxt = ST_DEGRADED;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_d     <= '0;
      valid_d    <= 1'b0;
      mis        <= '0;
      lane_fault <= '0;
      voter_err  <= 1'b0;
      err_cnt    <= '0;
      state      <= ST_OK;
      // NOTE: the run counters are a tiny array whose start value matters, so it is reset.
      for (int i = 0; i < 3; i++) run[i] <= '0;
    end else begin
      lane_d  <= {c, b, a};
      valid_d <= en;
      if (clr) begin
        mis        <= '0;
        lane_fault <= '0;
        voter_err  <= 1'b0;
        err_cnt    <= '0;
        state      <= ST_OK;
        for (int i = 0; i < 3; i++) run[i] <= '0;
      end else begin
        mis        <= m;
        lane_fault <= lf_nxt;
        voter_err  <= ve_nxt;
        err_cnt    <= cnt_nxt;
        state      <= state_nxt;
        for (int i = 0; i < 3; i++) run[i] <= run_nxt[i];
      end
    end
  end

  assign status = state;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Scoreboard bench for tmr_fault_monitor: directed lane vectors, a behavioural
// voter in front, a reference model pushing expected outputs, and a popping monitor.
module tb_tmr_fault_monitor;

  localparam int FT = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          clr;
  logic          a;
  logic          b;
  logic          c;
  logic          y;
  logic          yflip;
  logic [2:0]    mis;
  logic [2:0]    lane_fault;
  logic          voter_err;
  logic [CW-1:0] err_cnt;
  logic [1:0]    status;

  tmr_fault_monitor #(.FAULT_THRESH(FT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .a(a), .b(b), .c(c), .y(y),
    .mis(mis), .lane_fault(lane_fault), .voter_err(voter_err),
    .err_cnt(err_cnt), .status(status)
  );

  always #5 clk = ~clk;

  // Voter model, with an override that inverts its output.
  always @(posedge clk or posedge rst) begin
    if (rst) y <= 1'b0;
    else     y <= ((a & b) | (a & c) | (b & c)) ^ yflip;
  end

  typedef struct packed {
    logic [2:0]    mis;
    logic [2:0]    lf;
    logic          ve;
    logic [CW-1:0] cnt;
    logic [1:0]    st;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state and the previously applied vector.
  int         m_run [3];
  logic [2:0] m_lf;
  logic       m_ve;
  int         m_cnt;
  int         m_st;
  logic [2:0] m_mis;
  logic       p_en;
  logic [2:0] p_lanes;
  logic       p_flip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({mis, lane_fault, voter_err, err_cnt, status});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_lf = '0; m_ve = 1'b0; m_cnt = 0; m_st = 0; m_mis = '0;
    p_en = 1'b0; p_lanes = '0; p_flip = 1'b0;
  endtask

  // Outcome of one clock edge: compare of the previous vector, unless clr now.
  task automatic model_step(input logic cl);
    logic       ymaj;
    logic       yv;
    logic [2:0] mm;
    int         nf;
    if (cl) begin
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      m_lf = '0; m_ve = 1'b0; m_cnt = 0; m_st = 0; m_mis = '0;
    end else begin
      ymaj = (p_lanes[0] & p_lanes[1]) | (p_lanes[0] & p_lanes[2]) | (p_lanes[1] & p_lanes[2]);
      yv   = ymaj ^ p_flip;
      for (int i = 0; i < 3; i++) begin
        mm[i] = p_en && (p_lanes[i] != yv);
        if (mm[i])     m_run[i] = (m_run[i] < FT) ? m_run[i] + 1 : FT;
        else if (p_en) m_run[i] = 0;
        if (m_run[i] == FT) m_lf[i] = 1'b1;
      end
      if ((mm != 3'b000) && (m_cnt < 255)) m_cnt++;
      if (p_en && (yv != ymaj)) m_ve = 1'b1;
      nf = $countones(m_lf);
      if (m_st != 2) begin
        if (nf >= 2 || m_ve) m_st = 2;
        else if (nf == 1)    m_st = 1;
      end
      m_mis = mm;
    end
  endtask

  task automatic drive(input logic e, input logic cl, input logic [2:0] lanes, input logic fl);
    exp_t x;
    @(negedge clk);
    en = e; clr = cl; {c, b, a} = lanes; yflip = fl;
    model_step(cl);
    x.mis = m_mis; x.lf = m_lf; x.ve = m_ve; x.cnt = CW'(m_cnt); x.st = 2'(m_st);
    q.push_back(x);
    p_en = e; p_lanes = lanes; p_flip = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 3'b000, 1'b0);
  endtask

  // Monitor: every edge produces a registered output set to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("scoreboard", outs(), 32'(e));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic x;
    rst = 1'b1; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; yflip = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), 32'h0);
    rst = 1'b0;

    // Healthy lanes, random common value.
    for (int i = 0; i < 20; i++) begin
      x = 1'($urandom_range(0, 1));
      drive(1'b1, 1'b0, {3{x}}, 1'b0);
    end
    idle(2);
    check("healthy_cnt", 32'(err_cnt), 32'd0);
    check("healthy_flags", {29'd0, lane_fault}, 32'd0);

    // Lane a off for 3 compares: below threshold.
    drive(1'b1, 1'b0, 3'b001, 1'b0);
    drive(1'b1, 1'b0, 3'b110, 1'b0);
    drive(1'b1, 1'b0, 3'b001, 1'b0);
    idle(2);
    check("three_mis_cnt", 32'(err_cnt), 32'd3);
    check("three_mis_lf", {29'd0, lane_fault}, 32'd0);

    drive(1'b1, 1'b1, 3'b000, 1'b0);
    idle(1);

    // Lane a off for 4 compares: latches, then 10 more.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, (i % 2 == 0) ? 3'b001 : 3'b110, 1'b0);
    idle(2);
    check("a_fault_lf", {29'd0, lane_fault}, 32'd1);
    check("a_fault_status", {30'd0, status}, 32'd1);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 3'b110, 1'b0);
    idle(2);
    check("a_fault_cnt14", 32'(err_cnt), 32'd14);
    check("a_fault_status2", {30'd0, status}, 32'd1);

    // Lane b off for 4 compares: second fault -> FAILED.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, (i % 2 == 0) ? 3'b010 : 3'b101, 1'b0);
    idle(2);
    check("b_fault_lf", {29'd0, lane_fault}, 32'd3);
    check("b_fault_status", {30'd0, status}, 32'd2);

    // clr on the edge that registers a mismatching compare.
    drive(1'b1, 1'b0, 3'b010, 1'b0);
    drive(1'b1, 1'b1, 3'b000, 1'b0);
    idle(2);
    check("clr_all", outs(), 32'h0);

    // en low holds run counts; re-enable completes the fault.
    drive(1'b1, 1'b0, 3'b001, 1'b0);
    drive(1'b1, 1'b0, 3'b001, 1'b0);
    drive(1'b0, 1'b0, 3'b001, 1'b0);
    drive(1'b0, 1'b0, 3'b001, 1'b0);
    drive(1'b1, 1'b0, 3'b001, 1'b0);
    drive(1'b1, 1'b0, 3'b001, 1'b0);
    idle(2);
    check("en_gap_lf", {29'd0, lane_fault}, 32'd1);
    check("en_gap_cnt", 32'(err_cnt), 32'd4);

    // Voter outputs a non-majority value once.
    drive(1'b1, 1'b1, 3'b000, 1'b0);
    idle(1);
    drive(1'b1, 1'b0, 3'b000, 1'b1);
    idle(2);
    check("voter_err", {31'd0, voter_err}, 32'd1);
    check("voter_err_status", {30'd0, status}, 32'd2);

    // Saturate the mismatch counter.
    for (int i = 0; i < 260; i++) drive(1'b1, 1'b0, (i % 2 == 0) ? 3'b100 : 3'b011, 1'b0);
    idle(2);
    check("cnt_saturate", 32'(err_cnt), 32'd255);

    // Asynchronous reset mid-run with flags set.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", outs(), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(3);
    check("post_reset", outs(), 32'h0);

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
